// File: rtl/serial_word_receiver.sv
// Deserializing receiver: turns MSB-first serial frames into WIDTH-bit words,
// with an optional even-parity bit, and presents them on a valid/ready output.
module serial_word_receiver #(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sdata_i,
    input  logic             sframe_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             parity_err_o,
    output logic             overrun_o,
    output logic             frame_err_o
);

    generate
        if (WIDTH == 0) begin : g_bad_width
            serial_word_receiver_width_must_be_nonzero u_bad_width ();
        end
    endgenerate

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               overrun_q, overrun_d;
    logic               frame_err_q, frame_err_d;

    logic               complete;
    logic [WIDTH-1:0]   word;
    logic               perr;
    logic [WIDTH-1:0]   shifted;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q;
        perr_d      = perr_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        complete    = 1'b0;
        word        = shreg_q;
        perr        = 1'b0;
        shifted     = (shreg_q << 1) | WIDTH'(sdata_i);

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        // A frame start wins over everything, including a completing bit.
        if (sframe_i) begin
            frame_err_d = (state_q != S_IDLE);
            if (WIDTH == 1) begin
                cnt_d = '0;
                if (PARITY_EN != 0) begin
                    shreg_d = WIDTH'(sdata_i);
                    state_d = S_PARITY;
                end else begin
                    state_d  = S_IDLE;
                    complete = 1'b1;
                    word     = WIDTH'(sdata_i);
                end
            end else begin
                shreg_d = WIDTH'(sdata_i);
                cnt_d   = CW'(1);
                state_d = S_SHIFT;
            end
        end else begin
            case (state_q)
                S_SHIFT: begin
                    shreg_d = shifted;
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                        end else begin
                            state_d  = S_IDLE;
                            complete = 1'b1;
                            word     = shifted;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_PARITY: begin
                    state_d  = S_IDLE;
                    complete = 1'b1;
                    word     = shreg_q;
                    perr     = ^{shreg_q, sdata_i};
                end
                default: begin
                end
            endcase
        end

        if (complete) begin
            data_d    = word;
            perr_d    = (PARITY_EN != 0) ? perr : 1'b0;
            overrun_d = valid_q && !ready_i;
            valid_d   = 1'b1;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign overrun_o    = overrun_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: one instance without and one with parity,
// driven by the same serial stream and checked against a frame-level model.
module tb_serial_word_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       sdata, sframe, ready;
    logic [7:0] data0, data1;
    logic       valid0, valid1, perr0, perr1, ovr0, ovr1, ferr0, ferr1;

    int total = 0;
    int bad   = 0;

    // reference model state, index 0 = no parity, 1 = parity
    int         m_cnt [2];
    logic [8:0] m_acc [2];
    logic [7:0] m_data[2];
    logic       m_valid[2], m_perr[2], m_ovr[2], m_ferr[2];

    always #5 clk = ~clk;

    serial_word_receiver #(.WIDTH(8), .PARITY_EN(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .sdata_i(sdata), .sframe_i(sframe),
        .data_o(data0), .valid_o(valid0), .ready_i(ready),
        .parity_err_o(perr0), .overrun_o(ovr0), .frame_err_o(ferr0));

    serial_word_receiver #(.WIDTH(8), .PARITY_EN(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .sdata_i(sdata), .sframe_i(sframe),
        .data_o(data1), .valid_o(valid1), .ready_i(ready),
        .parity_err_o(perr1), .overrun_o(ovr1), .frame_err_o(ferr1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_acc[i] = '0; m_data[i] = '0;
            m_valid[i] = 0; m_perr[i] = 0; m_ovr[i] = 0; m_ferr[i] = 0;
        end
    endtask

    // A frame is 8 data bits plus i parity bits; collect them and deliver the word.
    task automatic model_step(input logic sf, input logic sd, input logic rdy);
        for (int i = 0; i < 2; i++) begin
            logic old_valid;
            old_valid  = m_valid[i];
            m_ovr[i]   = 0;
            m_ferr[i]  = 0;
            if (old_valid && rdy) m_valid[i] = 0;
            if (sf) begin
                if (m_cnt[i] > 0) m_ferr[i] = 1;
                m_cnt[i] = 1;
                m_acc[i] = {8'd0, sd};
            end else if (m_cnt[i] > 0) begin
                m_cnt[i]++;
                m_acc[i] = {m_acc[i][7:0], sd};
            end
            if (m_cnt[i] == 8 + i) begin
                m_ovr[i]   = old_valid && !rdy;
                m_data[i]  = (i == 1) ? m_acc[i][8:1] : m_acc[i][7:0];
                m_perr[i]  = (i == 1) ? ^m_acc[i] : 1'b0;
                m_valid[i] = 1;
                m_cnt[i]   = 0;
            end
        end
    endtask

    task automatic check_model();
        check("data0",  data0,  m_data[0]);
        check("valid0", valid0, m_valid[0]);
        check("perr0",  perr0,  m_perr[0]);
        check("ovr0",   ovr0,   m_ovr[0]);
        check("ferr0",  ferr0,  m_ferr[0]);
        check("data1",  data1,  m_data[1]);
        check("valid1", valid1, m_valid[1]);
        check("perr1",  perr1,  m_perr[1]);
        check("ovr1",   ovr1,   m_ovr[1]);
        check("ferr1",  ferr1,  m_ferr[1]);
    endtask

    task automatic step(input logic sf, input logic sd, input logic rdy);
        @(negedge clk);
        sframe = sf; sdata = sd; ready = rdy;
        model_step(sf, sd, rdy);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic send_frame(input logic [7:0] w, input logic par, input logic rdy);
        for (int b = 7; b >= 0; b--) step(b == 7, w[b], rdy);
        step(1'b0, par, rdy);
    endtask

    typedef struct {
        logic sf, sd, rdy;
        logic v0; logic [7:0] d0;
        logic v1; logic [7:0] d1; logic p1;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [7:0] w;
        int ferr_cnt;

        tbl[0] = '{1, 1, 1, 0, 8'h00, 0, 8'h00, 0};
        tbl[1] = '{0, 0, 1, 0, 8'h00, 0, 8'h00, 0};
        tbl[2] = '{0, 1, 1, 0, 8'h00, 0, 8'h00, 0};
        tbl[3] = '{0, 0, 1, 0, 8'h00, 0, 8'h00, 0};
        tbl[4] = '{0, 0, 1, 0, 8'h00, 0, 8'h00, 0};
        tbl[5] = '{0, 1, 1, 0, 8'h00, 0, 8'h00, 0};
        tbl[6] = '{0, 0, 1, 0, 8'h00, 0, 8'h00, 0};
        tbl[7] = '{0, 1, 1, 1, 8'hA5, 0, 8'h00, 0};
        tbl[8] = '{0, 0, 1, 0, 8'hA5, 1, 8'hA5, 0};
        tbl[9] = '{0, 0, 1, 0, 8'hA5, 0, 8'hA5, 0};

        rst = 1'b1; sframe = 1'b0; sdata = 1'b0; ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid0", valid0, 1'b0);
        check("rst_data1",  data1,  8'h00);
        check("rst_perr1",  perr1,  1'b0);

        // 0xA5 frame followed by its (even) parity bit
        for (int k = 0; k < 10; k++) begin
            step(tbl[k].sf, tbl[k].sd, tbl[k].rdy);
            check("tbl_v0", valid0, tbl[k].v0);
            check("tbl_d0", data0,  tbl[k].d0);
            check("tbl_v1", valid1, tbl[k].v1);
            check("tbl_d1", data1,  tbl[k].d1);
            check("tbl_p1", perr1,  tbl[k].p1);
        end

        // parity good then parity bad
        send_frame(8'h3C, 1'b0, 1'b1);
        check("par_ok", perr1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b1);
        check("par_bad",   perr1,  1'b1);
        check("par_valid", valid1, 1'b1);
        check("par_data",  data1,  8'h3C);
        step(1'b0, 1'b0, 1'b1);

        // back-to-back with downstream stalled
        send_frame(8'h01, 1'b1, 1'b0);
        for (int b = 7; b >= 0; b--) begin
            w = 8'h02;
            step(b == 7, w[b], 1'b0);
        end
        check("b2b_ovr0",   ovr0,   1'b1);
        check("b2b_data0",  data0,  8'h02);
        check("b2b_valid0", valid0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("b2b_ovr0_end", ovr0, 1'b0);
        check("b2b_ovr1",     ovr1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("b2b_accept0", valid0, 1'b0);
        check("b2b_accept1", valid1, 1'b0);

        // aborted 0xFF after four bits, then 0x81
        ferr_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            step(b == 0, 1'b1, 1'b1);
            ferr_cnt += ferr0;
        end
        w = 8'h81;
        for (int b = 7; b >= 0; b--) begin
            step(b == 7, w[b], 1'b1);
            ferr_cnt += ferr0;
            check("abort_noword", valid0, b == 0);
        end
        step(1'b0, 1'b0, 1'b1);
        check("abort_ferr_cnt", ferr_cnt, 1);
        check("abort_data1", data1, 8'h81);
        check("abort_ovr0",  ovr0,  1'b0);

        // async reset mid-frame while a word is pending
        send_frame(8'hC3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("pre_rst_valid0", valid0, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_valid0", valid0, 1'b0);
        check("arst_data0",  data0,  8'h00);
        check("arst_valid1", valid1, 1'b0);
        check("arst_data1",  data1,  8'h00);
        check("arst_flags",  {perr0, perr1, ovr0, ovr1, ferr0, ferr1}, 6'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0);
        check("post_rst_data0", data0, 8'h5A);
        check("post_rst_data1", data1, 8'h5A);

        // completion coinciding with acceptance
        w = 8'h96;
        for (int b = 7; b >= 0; b--) step(b == 7, w[b], b == 0);
        check("same_valid0", valid0, 1'b1);
        check("same_data0",  data0,  8'h96);
        check("same_ovr0",   ovr0,   1'b0);
        step(1'b0, 1'b0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) == 0, 1'($urandom), $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
